// File: rtl/ffo_position_decoder.sv
// rtl/ffo_position_decoder.sv - rebuilds an N-bit vector from a stream of FFO (valid, position) beats
//
// Purpose:
//   Each accepted beat with in_v=1 sets bit in_p of an accumulator. A beat
//   with in_last=1 closes the frame. The rebuilt word, the number of
//   positioned beats and a duplicate flag are then presented on a
//   valid/ready output register. Index 0 of every vector is the first
//   (most-significant) position, matching the find-first-one encoder.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  beat can be accepted this cycle
//   in_v       in   FFO valid bit (0: beat carries no position)
//   in_p       in   FFO position, 0..N-1
//   in_last    in   final beat of the frame
//   out_valid  out  rebuilt frame available
//   out_ready  in   consumer accepts the frame
//   out_word   out  rebuilt vector, [0] is the first position
//   out_count  out  positioned beats in the frame, saturating
//   out_dup    out  some position arrived while already set

module ffo_position_decoder #(
    parameter  int N  = 32,
    localparam int PW = $clog2(N),
    localparam int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_v,
    input  logic [PW-1:0] in_p,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:N-1]  out_word,
    output logic [CW-1:0] out_count,
    output logic          out_dup
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q,     state_d;
    logic [0:N-1]  acc_q,       acc_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          dup_q,       dup_d;
    logic          out_valid_q, out_valid_d;
    logic [0:N-1]  out_word_q,  out_word_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_dup_q,   out_dup_d;

    logic          accept;
    logic [0:N-1]  onehot;
    logic [0:N-1]  acc_next;
    logic [CW-1:0] cnt_next;
    logic          dup_next;

    // Ready depends only on state and out_ready: in HOLD a beat may enter on
    // the same edge the pending frame is handshaken, never earlier.
    assign in_ready = (state_q == ST_ACC) | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        onehot       = '0;
        onehot[in_p] = 1'b1;
    end

    // Frame contents as they would be after absorbing the current beat.
    // A beat without a position leaves everything untouched.
    always_comb begin
        acc_next = acc_q;
        cnt_next = cnt_q;
        dup_next = dup_q;
        if (in_v) begin
            acc_next = acc_q | onehot;
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            dup_next = dup_q | acc_q[in_p];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dup_d       = dup_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_count_d = out_count_q;
        out_dup_d   = out_dup_q;

        // The pending frame leaves on this edge; a closing beat below may
        // immediately refill the output register.
        if (state_q == ST_HOLD && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end

        if (accept) begin
            if (in_last) begin
                out_word_d  = acc_next;
                out_count_d = cnt_next;
                out_dup_d   = dup_next;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                dup_d       = 1'b0;
                state_d     = ST_HOLD;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
                dup_d = dup_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            dup_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_count_q <= '0;
            out_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dup_q       <= dup_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_count_q <= out_count_d;
            out_dup_q   <= out_dup_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_count = out_count_q;
    assign out_dup   = out_dup_q;

endmodule

// File: tb/tb_ffo_position_decoder.sv
// tb/tb_ffo_position_decoder.sv - self-checking bench for ffo_position_decoder

module tb_ffo_position_decoder;

    localparam int N  = 32;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N) + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_v = 1'b0;
    logic [PW-1:0] in_p = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [0:N-1]  out_word;
    logic [CW-1:0] out_count;
    logic          out_dup;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_bp = 1'b0;

    ffo_position_decoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_v      (in_v),
        .in_p      (in_p),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    always #5 clk = ~clk;

    // Reference model: per-position hit counts for the open frame, and the
    // frame last presented. Word, count and dup are derived from the hits.
    int           hits[N];
    bit           m_valid;
    logic [0:N-1] m_word;
    int           m_count;
    bit           m_dup;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (hits[i]) hits[i] = 0;
            m_valid = 1'b0;
            m_word  = '0;
            m_count = 0;
            m_dup   = 1'b0;
        end else begin
            bit acc_now;
            acc_now = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (acc_now) begin
                if (in_v) hits[in_p]++;
                if (in_last) begin
                    int total;
                    total = 0;
                    m_dup = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        m_word[i] = (hits[i] > 0);
                        total += hits[i];
                        if (hits[i] > 1) m_dup = 1'b1;
                        hits[i] = 0;
                    end
                    m_count = (total > CMAX) ? CMAX : total;
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle compare the DUT against the model.
    always @(negedge clk) begin
        chk("model in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("model out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("model out_word", 64'(out_word), 64'(m_word));
            chk("model out_count", 64'(out_count), 64'(m_count));
            chk("model out_dup", 64'(out_dup), 64'(m_dup));
        end
    end

    // Random back-pressure, driven just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
    end

    // Call just after a rising edge; returns 1 time unit after the edge that
    // accepted the beat.
    task automatic send_beat(input bit v, input int p, input bit last);
        bit rdy;
        int guard;
        in_valid = 1'b1;
        in_v     = v;
        in_p     = PW'(p);
        in_last  = last;
        guard    = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                chk("beat accept timeout", 64'(0), 64'(1));
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_v     = $urandom_range(0, 1);
        in_p     = PW'($urandom);
        in_last  = $urandom_range(0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [0:N-1] vec;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset out_word", 64'(out_word), 64'(0));
        chk("reset out_count", 64'(out_count), 64'(0));
        chk("reset out_dup", 64'(out_dup), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Positions 3, 0, 31
        send_beat(1, 3, 0);
        send_beat(1, 0, 0);
        send_beat(1, 31, 1);
        @(negedge clk);
        chk("t1 out_valid", 64'(out_valid), 64'(1));
        chk("t1 out_word", 64'(out_word), 64'h9000_0001);
        chk("t1 out_count", 64'(out_count), 64'(3));
        chk("t1 out_dup", 64'(out_dup), 64'(0));
        @(negedge clk);
        chk("t1 out_valid one cycle", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // Empty frame
        send_beat(0, 17, 1);
        @(negedge clk);
        chk("t2 out_valid", 64'(out_valid), 64'(1));
        chk("t2 out_word", 64'(out_word), 64'(0));
        chk("t2 out_count", 64'(out_count), 64'(0));
        chk("t2 out_dup", 64'(out_dup), 64'(0));
        @(posedge clk); #1;

        // Duplicates 5, 5, 7
        send_beat(1, 5, 0);
        send_beat(1, 5, 0);
        send_beat(1, 7, 1);
        @(negedge clk);
        chk("t3 out_word", 64'(out_word), 64'h0500_0000);
        chk("t3 out_count", 64'(out_count), 64'(3));
        chk("t3 out_dup", 64'(out_dup), 64'(1));
        @(posedge clk); #1;

        // Held output, back-to-back reload
        out_ready = 1'b0;
        send_beat(1, 2, 1);
        in_valid = 1'b1; in_v = 1'b1; in_p = PW'(9); in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 in_ready held", 64'(in_ready), 64'(0));
            chk("t4 out_word held", 64'(out_word), 64'h2000_0000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4 in_ready release", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4 out_valid reload", 64'(out_valid), 64'(1));
        chk("t4 out_word reload", 64'(out_word), 64'h0040_0000);
        @(posedge clk); #1;

        // Reset mid-frame
        send_beat(1, 1, 0);
        send_beat(1, 4, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(1, 6, 1);
        @(negedge clk);
        chk("t5 out_word", 64'(out_word), 64'h0200_0000);
        chk("t5 out_count", 64'(out_count), 64'(1));
        @(posedge clk); #1;

        // Count saturation
        for (int i = 0; i < 70; i++) send_beat(1, 0, 0);
        send_beat(1, 0, 1);
        @(negedge clk);
        chk("sat out_count", 64'(out_count), 64'(CMAX));
        chk("sat out_dup", 64'(out_dup), 64'(1));
        @(posedge clk); #1;

        // Random vectors with random back-pressure
        rand_bp = 1'b1;
        for (int f = 0; f < 150; f++) begin
            int last_idx;
            case ($urandom_range(0, 4))
                0:       vec = '0;
                1:       vec = N'($urandom) & N'($urandom) & N'($urandom);
                2:       vec = N'($urandom) | N'($urandom);
                default: vec = N'($urandom);
            endcase
            last_idx = -1;
            for (int i = 0; i < N; i++) if (vec[i]) last_idx = i;
            if (last_idx < 0) begin
                send_beat(0, $urandom_range(0, N - 1), 1);
            end else begin
                for (int i = 0; i < N; i++)
                    if (vec[i]) send_beat(1, i, i == last_idx);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
